// File: rtl/sum_sq_accum_pkg.sv
// Shared constants, types and the saturating-add helper for the sum-of-squares
// accumulator and the square-root stage that consumes its output.
package sum_sq_accum_pkg;

  localparam int unsigned SUMSQ_OUT_W           = 32;
  localparam logic [31:0] SUMSQ_SAT             = 32'hFFFF_FFFF;
  localparam int unsigned SUMSQ_ELEM_W_DEFAULT  = 16;
  localparam int unsigned SUMSQ_MAX_LEN_DEFAULT = 16;

  typedef logic [SUMSQ_OUT_W-1:0] sumsq_word_t;

  typedef struct packed {
    logic        sat;
    sumsq_word_t value;
  } sumsq_add_t;

  // 33-bit add clamped to all-ones; an already-saturated accumulator stays saturated
  function automatic sumsq_add_t sumsq_sat_add(input sumsq_word_t a,
                                               input sumsq_word_t b,
                                               input logic        sat_in);
    logic [SUMSQ_OUT_W:0] wide;
    sumsq_add_t           r;
    wide    = {1'b0, a} + {1'b0, b};
    r.sat   = sat_in | wide[SUMSQ_OUT_W];
    r.value = r.sat ? SUMSQ_SAT : wide[SUMSQ_OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/sum_sq_square.sv
// Registered squarer (first pipeline stage). Kept separate so a DSP-mapped or
// multi-cycle multiplier can be swapped in without touching accumulation.
module sum_sq_square
  import sum_sq_accum_pkg::*;
#(
  parameter int unsigned ELEM_W = SUMSQ_ELEM_W_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [ELEM_W-1:0] elem_in,
  input  logic                     elem_valid,
  input  logic                     elem_last,
  output logic [SUMSQ_OUT_W-1:0]   sq_r,
  output logic                     a_valid,
  output logic                     a_last
);

  logic signed [2*ELEM_W-1:0] elem_ext;
  logic signed [2*ELEM_W-1:0] prod;
  logic [SUMSQ_OUT_W-1:0]     sq_ext;

  // Square at full 2*ELEM_W width so the most-negative input cannot overflow
  always_comb begin
    elem_ext                = (2*ELEM_W)'(elem_in);
    prod                    = elem_ext * elem_ext;
    sq_ext                  = '0;
    sq_ext[2*ELEM_W-1:0]    = prod;
  end

  // Capture the square with its valid/last qualifiers; last is masked by valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sq_r    <= '0;
      a_valid <= 1'b0;
      a_last  <= 1'b0;
    end else begin
      a_valid <= elem_valid;
      a_last  <= elem_valid & elem_last;
      if (elem_valid) sq_r <= sq_ext;
    end
  end

endmodule

// File: rtl/sum_sq_accum.sv
// Streaming sum-of-squares accumulator: one signed element per cycle, one
// 32-bit saturating result pulse per vector, closed by elem_last or MAX_LEN.
module sum_sq_accum
  import sum_sq_accum_pkg::*;
#(
  parameter int unsigned ELEM_W  = SUMSQ_ELEM_W_DEFAULT,
  parameter int unsigned MAX_LEN = SUMSQ_MAX_LEN_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [ELEM_W-1:0] elem_in,
  input  logic                     elem_valid,
  input  logic                     elem_last,
  output logic [SUMSQ_OUT_W-1:0]   data_out,
  output logic                     data_valid,
  output logic                     sat_flag,
  output logic                     len_err
);

  localparam int unsigned      CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  logic [SUMSQ_OUT_W-1:0] sq_r;
  logic                   a_valid;
  logic                   a_last;
  logic [SUMSQ_OUT_W-1:0] acc;
  logic [CNT_W-1:0]       cnt;
  logic                   sat_q;
  sumsq_add_t             add;
  logic                   close;

  sum_sq_square #(
    .ELEM_W (ELEM_W)
  ) u_square (
    .clock      (clock),
    .reset      (reset),
    .elem_in    (elem_in),
    .elem_valid (elem_valid),
    .elem_last  (elem_last),
    .sq_r       (sq_r),
    .a_valid    (a_valid),
    .a_last     (a_last)
  );

  // Next accumulator value and vector-close decision for the element in stage B
  always_comb begin
    add   = sumsq_sat_add(acc, sq_r, sat_q);
    close = a_last | (cnt == CNT_LAST);
  end

  // Accumulate; on close emit the result and restart from zero in the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      cnt        <= '0;
      sat_q      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sat_flag   <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      data_out   <= '0;
      data_valid <= 1'b0;
      sat_flag   <= 1'b0;
      len_err    <= 1'b0;
      if (a_valid) begin
        if (close) begin
          data_out   <= add.value;
          data_valid <= 1'b1;
          sat_flag   <= add.sat;
          len_err    <= ~a_last;
          acc        <= '0;
          cnt        <= '0;
          sat_q      <= 1'b0;
        end else begin
          acc   <= add.value;
          cnt   <= cnt + CNT_W'(1);
          sat_q <= add.sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_sq_accum.sv
// Self-checking bench for sum_sq_accum: directed scenarios plus randomized
// traffic, compared against an arithmetic per-vector model.
module tb_sum_sq_accum;
  import sum_sq_accum_pkg::*;

  localparam int ELEM_W  = 16;
  localparam int MAX_LEN = 16;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic signed [ELEM_W-1:0] elem_in = '0;
  logic                     elem_valid = 1'b0;
  logic                     elem_last = 1'b0;
  logic [31:0]              data_out;
  logic                     data_valid;
  logic                     sat_flag;
  logic                     len_err;

  sum_sq_accum #(
    .ELEM_W  (ELEM_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .elem_in    (elem_in),
    .elem_valid (elem_valid),
    .elem_last  (elem_last),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sat_flag   (sat_flag),
    .len_err    (len_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        s;
    logic        l;
  } exp_t;

  // Model: exact vector sum in 64 bits, result visible two edges after input
  longint m_sum;
  int     m_cnt;
  exp_t   m_pend;
  exp_t   m_out;

  task automatic clear_model();
    m_sum  = 0;
    m_cnt  = 0;
    m_pend = '0;
    m_out  = '0;
  endtask

  task automatic cycle(input logic v, input logic l, input int x);
    longint xs;
    elem_valid = v;
    elem_last  = l;
    elem_in    = x[ELEM_W-1:0];
    @(posedge clock);
    m_out  = m_pend;
    m_pend = '0;
    if (v) begin
      xs    = longint'(elem_in);
      m_sum = m_sum + xs * xs;
      m_cnt++;
      if (l || m_cnt == MAX_LEN) begin
        m_pend.v = 1'b1;
        m_pend.s = (m_sum > 64'sh0_FFFF_FFFF);
        m_pend.d = m_pend.s ? 32'hFFFF_FFFF : m_sum[31:0];
        m_pend.l = !l;
        m_sum    = 0;
        m_cnt    = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got v=%b d=%h s=%b l=%b, want all zero",
                 data_valid, data_out, sat_flag, len_err);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 0);
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_idle: got v=%b d=%h, want all zero", data_valid, data_out);
      end
    end
  endtask

  task automatic test_basic();
    int xs[5] = '{3, 4, 0, 0, 0};
    bit vs[5] = '{1, 1, 0, 0, 0};
    bit ls[5] = '{0, 1, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      cycle(vs[i], ls[i], xs[i]);
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== {m_out.v, m_out.d, m_out.s, m_out.l}) begin
        n_fail++;
        $display("FAIL basic[%0d]: got v=%b d=%0d s=%b l=%b, want v=%b d=%0d s=%b l=%b", i,
                 data_valid, data_out, sat_flag, len_err, m_out.v, m_out.d, m_out.s, m_out.l);
      end
      if (i == 2) begin
        n_checks++;
        if ({data_valid, data_out, sat_flag, len_err} !== {1'b1, 32'd25, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL basic_25: got v=%b d=%0d s=%b l=%b, want v=1 d=25 s=0 l=0",
                   data_valid, data_out, sat_flag, len_err);
        end
      end
    end
  endtask

  task automatic test_extremes();
    int xs[4] = '{-32768, 32767, 0, 0};
    bit vs[4] = '{1, 1, 0, 0};
    logic [31:0] want[4] = '{32'd0, 32'd1073741824, 32'd1073676289, 32'd0};
    for (int i = 0; i < 4; i++) begin
      cycle(vs[i], vs[i], xs[i]);
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== {m_out.v, m_out.d, m_out.s, m_out.l}) begin
        n_fail++;
        $display("FAIL extremes[%0d]: got v=%b d=%0d, want v=%b d=%0d", i,
                 data_valid, data_out, m_out.v, m_out.d);
      end
      if (i == 1 || i == 2) begin
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== want[i]) begin
          n_fail++;
          $display("FAIL extremes_const[%0d]: got v=%b d=%0d, want v=1 d=%0d", i,
                   data_valid, data_out, want[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) begin
      cycle(i < 4, i == 3, -32768);
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== {m_out.v, m_out.d, m_out.s, m_out.l}) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got v=%b d=%h s=%b, want v=%b d=%h s=%b", i,
                 data_valid, data_out, sat_flag, m_out.v, m_out.d, m_out.s);
      end
      if (i == 4) begin
        n_checks++;
        if ({data_valid, data_out, sat_flag, len_err} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL saturation_const: got v=%b d=%h s=%b l=%b, want v=1 d=ffffffff s=1 l=0",
                   data_valid, data_out, sat_flag, len_err);
        end
      end
    end
  endtask

  task automatic test_forced_close();
    for (int i = 0; i < 19; i++) begin
      if (i < MAX_LEN)       cycle(1'b1, 1'b0, 1);
      else if (i == MAX_LEN) cycle(1'b1, 1'b1, 2);
      else                   cycle(1'b0, 1'b0, 0);
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== {m_out.v, m_out.d, m_out.s, m_out.l}) begin
        n_fail++;
        $display("FAIL forced[%0d]: got v=%b d=%0d l=%b, want v=%b d=%0d l=%b", i,
                 data_valid, data_out, len_err, m_out.v, m_out.d, m_out.l);
      end
      if (i == MAX_LEN) begin
        n_checks++;
        if ({data_valid, data_out, len_err} !== {1'b1, 32'd16, 1'b1}) begin
          n_fail++;
          $display("FAIL forced_len_err: got v=%b d=%0d l=%b, want v=1 d=16 l=1",
                   data_valid, data_out, len_err);
        end
      end
      if (i == MAX_LEN + 1) begin
        n_checks++;
        if ({data_valid, data_out, len_err} !== {1'b1, 32'd4, 1'b0}) begin
          n_fail++;
          $display("FAIL forced_next: got v=%b d=%0d l=%b, want v=1 d=4 l=0",
                   data_valid, data_out, len_err);
        end
      end
    end
  endtask

  task automatic test_gap();
    int xs[8] = '{5, 0, 0, 0, 12, 0, 0, 0};
    bit vs[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    bit ls[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      cycle(vs[i], ls[i], xs[i]);
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== {m_out.v, m_out.d, m_out.s, m_out.l}) begin
        n_fail++;
        $display("FAIL gap[%0d]: got v=%b d=%0d, want v=%b d=%0d", i,
                 data_valid, data_out, m_out.v, m_out.d);
      end
      if (i == 5) begin
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 32'd169) begin
          n_fail++;
          $display("FAIL gap_169: got v=%b d=%0d, want v=1 d=169", data_valid, data_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 7);
    cycle(1'b1, 1'b0, 7);
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    reset      = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if ({data_valid, data_out, sat_flag, len_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got v=%b d=%0d, want all zero", data_valid, data_out);
    end
    @(posedge clock);
    #2;
    n_checks++;
    if ({data_valid, data_out, sat_flag, len_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got v=%b d=%0d, want all zero", data_valid, data_out);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(i == 0, i == 0, 2);
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== {m_out.v, m_out.d, m_out.s, m_out.l}) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got v=%b d=%0d, want v=%b d=%0d", i,
                 data_valid, data_out, m_out.v, m_out.d);
      end
      if (i == 1) begin
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 32'd4) begin
          n_fail++;
          $display("FAIL reset_mid_4: got v=%b d=%0d, want v=1 d=4", data_valid, data_out);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int x;
    for (int i = 0; i < 12; i++) begin
      x = (i < 10) ? (int'($urandom_range(0, 65535)) - 32768) : 0;
      cycle(i < 10, i < 10, x);
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== {m_out.v, m_out.d, m_out.s, m_out.l}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got v=%b d=%0d, want v=%b d=%0d", i,
                 data_valid, data_out, m_out.v, m_out.d);
      end
    end
  endtask

  task automatic test_random();
    int  x;
    bit  v;
    bit  l;
    int  pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0:       x = -32768;
        1:       x = 32767;
        2:       x = int'($urandom_range(0, 15)) - 8;
        default: x = int'($urandom_range(0, 65535)) - 32768;
      endcase
      if (i >= 2990) v = 1'b0;
      cycle(v, l, x);
      if (m_out.v) pulses++;
      n_checks++;
      if ({data_valid, data_out, sat_flag, len_err} !== {m_out.v, m_out.d, m_out.s, m_out.l}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b d=%h s=%b l=%b, want v=%b d=%h s=%b l=%b", i,
                 data_valid, data_out, sat_flag, len_err, m_out.v, m_out.d, m_out.s, m_out.l);
      end
    end
    n_checks++;
    if (pulses < 50) begin
      n_fail++;
      $display("FAIL random_activity: got %0d result pulses, want at least 50", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_saturation();
    test_forced_close();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
